iter_shift_reg: RTL

//   Multicycle iterative shift/rotate register for the MIPS datapath; its result drives
//   the RegShiftOut input of the register-write-data mux.

---
 rtl/iter_shift_reg.sv | 108 ++++++++++
 1 files changed

// File: rtl/iter_shift_reg.sv
// Multicycle iterative shift/rotate unit: loads an operand, applies one 1-bit
// step per clock, then holds the result for the register-write-data mux.
module iter_shift_reg #(
  parameter int unsigned DATA_W  = 32,
  parameter int unsigned SHAMT_W = 5
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               start,
  input  logic [2:0]         shift_op,
  input  logic [DATA_W-1:0]  data_in,
  input  logic [SHAMT_W-1:0] shamt,
  output logic               busy,
  output logic               done,
  output logic [DATA_W-1:0]  shift_out
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    DONE  = 2'd2
  } state_t;

  typedef enum logic [2:0] {
    OP_LOAD = 3'd0,
    OP_SLL  = 3'd1,
    OP_SRL  = 3'd2,
    OP_SRA  = 3'd3,
    OP_ROR  = 3'd4,
    OP_ROL  = 3'd5
  } op_t;

  state_t             state;
  op_t                op;
  logic [SHAMT_W-1:0] cnt;

  // Reserved encodings 11x collapse onto LOAD.
  function automatic op_t decode(input logic [2:0] code);
    op_t r;
    case (code)
      3'd1:    r = OP_SLL;
      3'd2:    r = OP_SRL;
      3'd3:    r = OP_SRA;
      3'd4:    r = OP_ROR;
      3'd5:    r = OP_ROL;
      default: r = OP_LOAD;
    endcase
    return r;
  endfunction

  function automatic logic [DATA_W-1:0] step(input logic [DATA_W-1:0] s, input op_t o);
    logic [DATA_W-1:0] r;
    case (o)
      OP_SLL:  r = {s[DATA_W-2:0], 1'b0};
      OP_SRL:  r = {1'b0, s[DATA_W-1:1]};
      OP_SRA:  r = {s[DATA_W-1], s[DATA_W-1:1]};
      OP_ROR:  r = {s[0], s[DATA_W-1:1]};
      OP_ROL:  r = {s[DATA_W-2:0], s[DATA_W-1]};
      default: r = s;
    endcase
    return r;
  endfunction

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state     <= IDLE;
      op        <= OP_LOAD;
      cnt       <= '0;
      shift_out <= '0;
      busy      <= 1'b0;
      done      <= 1'b0;
    end else begin
      case (state)
        SHIFT: begin
          shift_out <= step(shift_out, op);
          cnt       <= cnt - SHAMT_W'(1);
          if (cnt == SHAMT_W'(1)) begin
            state <= DONE;
            busy  <= 1'b0;
            done  <= 1'b1;
          end
        end
        default: begin
          // IDLE and DONE both accept a new request, giving back-to-back chaining.
          if (start) begin
            shift_out <= data_in;
            cnt       <= shamt;
            op        <= decode(shift_op);
            if (decode(shift_op) == OP_LOAD || shamt == '0) begin
              state <= DONE;
              busy  <= 1'b0;
              done  <= 1'b1;
            end else begin
              state <= SHIFT;
              busy  <= 1'b1;
              done  <= 1'b0;
            end
          end else begin
            state <= IDLE;
            busy  <= 1'b0;
            done  <= 1'b0;
          end
        end
      endcase
    end
  end

endmodule
